// File: rtl/dht11_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dht11_pkg
// Brief    : Shared states, ASCII constants and line lengths for the reporter
// Revision : 1.0
// ============================================================================
package dht11_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CONV     = 2'd1,
        ST_SEND     = 2'd2,
        ST_SEND_ERR = 2'd3
    } state_t;

    localparam logic [7:0] c_ASCII_H     = 8'h48;
    localparam logic [7:0] c_ASCII_T     = 8'h54;
    localparam logic [7:0] c_ASCII_COLON = 8'h3A;
    localparam logic [7:0] c_ASCII_DOT   = 8'h2E;
    localparam logic [7:0] c_ASCII_SPACE = 8'h20;
    localparam logic [7:0] c_ASCII_E     = 8'h45;
    localparam logic [7:0] c_ASCII_R     = 8'h52;
    localparam logic [7:0] c_ASCII_CR    = 8'h0D;
    localparam logic [7:0] c_ASCII_LF    = 8'h0A;
    localparam logic [7:0] c_ASCII_0     = 8'h30;
    localparam logic [7:0] c_ASCII_9     = 8'h39;

    localparam logic [4:0] c_LEN_VALID_CRLF = 5'd17;
    localparam logic [4:0] c_LEN_VALID_LF   = 5'd16;
    localparam logic [4:0] c_LEN_ERR_CRLF   = 5'd5;
    localparam logic [4:0] c_LEN_ERR_LF     = 5'd4;

    function automatic logic [7:0] digit_ascii(input logic [3:0] d);
        return c_ASCII_0 + {4'h0, d};
    endfunction

    // The decimal byte is a raw binary value; anything past 9 is clamped.
    function automatic logic [7:0] dec_ascii(input logic [7:0] v);
        return (v > 8'd9) ? c_ASCII_9 : digit_ascii(v[3:0]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bin8_to_bcd.sv
`default_nettype none
// ============================================================================
// Module   : bin8_to_bcd
// Brief    : Sequential double-dabble: start, 8 shift cycles, one-cycle done
// Revision : 1.0
// ============================================================================
module bin8_to_bcd
    import dht11_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  bin,
    output logic        done,
    output logic [11:0] bcd
);

    logic [7:0]  r_bin;
    logic [11:0] r_bcd;
    logic [2:0]  r_cnt;
    logic        r_busy;
    logic        r_done;
    logic [10:0] w_adj;

    function automatic logic [3:0] adj3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    // Hundreds never reaches 5 for an 8-bit input, so it needs no adjust.
    assign w_adj = {r_bcd[10:8], adj3(r_bcd[7:4]), adj3(r_bcd[3:0])};

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_bin  <= 8'h00;
            r_bcd  <= 12'h000;
            r_cnt  <= 3'd0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_busy) begin
                r_bcd <= {w_adj, r_bin[7]};
                r_bin <= {r_bin[6:0], 1'b0};
                r_cnt <= r_cnt + 3'd1;
                if (r_cnt == 3'd7) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end else if (start) begin
                r_bin  <= bin;
                r_bcd  <= 12'h000;
                r_cnt  <= 3'd0;
                r_busy <= 1'b1;
            end
        end
    end

    assign done = r_done;
    assign bcd  = r_bcd;

endmodule
`default_nettype wire

// File: rtl/dht11_uart_reporter.sv
`default_nettype none
// ============================================================================
// Module   : dht11_uart_reporter
// Brief    : Latches DHT11 results and streams an ASCII report line to a UART
// Revision : 1.0
// ============================================================================
module dht11_uart_reporter
    import dht11_pkg::*;
#(
    parameter bit SEND_ERR = 1'b1,
    parameter bit EOL_CRLF = 1'b1
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] humidity,
    input  logic [15:0] temperature,
    input  logic        dht11_done,
    input  logic        dht11_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic [15:0] frame_cnt,
    output logic [7:0]  err_cnt,
    output logic [7:0]  drop_cnt
);

    localparam logic [4:0] c_LAST_VALID =
        (EOL_CRLF ? c_LEN_VALID_CRLF : c_LEN_VALID_LF) - 5'd1;
    localparam logic [4:0] c_LAST_ERR =
        (EOL_CRLF ? c_LEN_ERR_CRLF : c_LEN_ERR_LF) - 5'd1;
    localparam logic [7:0] c_EOL_FIRST = EOL_CRLF ? c_ASCII_CR : c_ASCII_LF;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_done_q;
    logic [15:0] r_hum;
    logic [15:0] r_temp;
    logic [11:0] r_hbcd;
    logic [11:0] r_tbcd;
    logic        r_conv_sel;
    logic        r_start;
    logic [4:0]  r_idx;
    logic [15:0] r_frame_cnt;
    logic [7:0]  r_err_cnt;
    logic [7:0]  r_drop_cnt;

    logic        w_cap;
    logic        w_accept;
    logic        w_xfer;
    logic        w_last;
    logic        w_sending;
    logic        w_bcd_done;
    logic [11:0] w_bcd;
    logic [7:0]  w_bcd_bin;
    logic [7:0]  w_tx_data;

    assign w_cap     = dht11_done & ~r_done_q;
    assign w_accept  = w_cap & en & (r_state == ST_IDLE);
    assign w_sending = (r_state == ST_SEND) || (r_state == ST_SEND_ERR);
    assign w_xfer    = w_sending & tx_ready;
    assign w_last    = (r_state == ST_SEND) ? (r_idx == c_LAST_VALID)
                                            : (r_idx == c_LAST_ERR);
    assign w_bcd_bin = r_conv_sel ? r_temp[15:8] : r_hum[15:8];

    bin8_to_bcd u_bcd (
        .clk   (clk),
        .rst   (rst),
        .start (r_start),
        .bin   (w_bcd_bin),
        .done  (w_bcd_done),
        .bcd   (w_bcd)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (dht11_valid)   w_state_nxt = ST_CONV;
                    else if (SEND_ERR) w_state_nxt = ST_SEND_ERR;
                end
            end
            ST_CONV: begin
                if (w_bcd_done && r_conv_sel) w_state_nxt = ST_SEND;
            end
            ST_SEND, ST_SEND_ERR: begin
                if (w_xfer && w_last) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Edge register resets high so a done already asserted at release is ignored.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_done_q    <= 1'b1;
            r_hum       <= 16'h0000;
            r_temp      <= 16'h0000;
            r_hbcd      <= 12'h000;
            r_tbcd      <= 12'h000;
            r_conv_sel  <= 1'b0;
            r_start     <= 1'b0;
            r_idx       <= 5'd0;
            r_frame_cnt <= 16'h0000;
            r_err_cnt   <= 8'h00;
            r_drop_cnt  <= 8'h00;
        end else begin
            r_done_q <= dht11_done;
            r_start  <= 1'b0;

            if (w_accept) begin
                r_hum      <= humidity;
                r_temp     <= temperature;
                r_conv_sel <= 1'b0;
                r_start    <= dht11_valid;
                if (!dht11_valid && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
            end

            if (w_cap && (r_state != ST_IDLE || !en) && r_drop_cnt != 8'hFF)
                r_drop_cnt <= r_drop_cnt + 8'd1;

            // Humidity converts first; its result kicks off the temperature byte.
            if (r_state == ST_CONV && w_bcd_done) begin
                if (!r_conv_sel) begin
                    r_hbcd     <= w_bcd;
                    r_conv_sel <= 1'b1;
                    r_start    <= 1'b1;
                end else begin
                    r_tbcd <= w_bcd;
                end
            end

            if (w_sending) begin
                if (w_xfer) r_idx <= r_idx + 5'd1;
            end else begin
                r_idx <= 5'd0;
            end

            if (w_xfer && w_last) r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    always_comb begin
        w_tx_data = 8'h00;
        if (r_state == ST_SEND) begin
            case (r_idx)
                5'd0:    w_tx_data = c_ASCII_H;
                5'd1:    w_tx_data = c_ASCII_COLON;
                5'd2:    w_tx_data = digit_ascii(r_hbcd[11:8]);
                5'd3:    w_tx_data = digit_ascii(r_hbcd[7:4]);
                5'd4:    w_tx_data = digit_ascii(r_hbcd[3:0]);
                5'd5:    w_tx_data = c_ASCII_DOT;
                5'd6:    w_tx_data = dec_ascii(r_hum[7:0]);
                5'd7:    w_tx_data = c_ASCII_SPACE;
                5'd8:    w_tx_data = c_ASCII_T;
                5'd9:    w_tx_data = c_ASCII_COLON;
                5'd10:   w_tx_data = digit_ascii(r_tbcd[11:8]);
                5'd11:   w_tx_data = digit_ascii(r_tbcd[7:4]);
                5'd12:   w_tx_data = digit_ascii(r_tbcd[3:0]);
                5'd13:   w_tx_data = c_ASCII_DOT;
                5'd14:   w_tx_data = dec_ascii(r_temp[7:0]);
                5'd15:   w_tx_data = c_EOL_FIRST;
                5'd16:   w_tx_data = c_ASCII_LF;
                default: w_tx_data = 8'h00;
            endcase
        end else if (r_state == ST_SEND_ERR) begin
            case (r_idx)
                5'd0:    w_tx_data = c_ASCII_E;
                5'd1:    w_tx_data = c_ASCII_R;
                5'd2:    w_tx_data = c_ASCII_R;
                5'd3:    w_tx_data = c_EOL_FIRST;
                5'd4:    w_tx_data = c_ASCII_LF;
                default: w_tx_data = 8'h00;
            endcase
        end
    end

    assign tx_data   = w_tx_data;
    assign tx_valid  = w_sending;
    assign busy      = (r_state != ST_IDLE);
    assign frame_cnt = r_frame_cnt;
    assign err_cnt   = r_err_cnt;
    assign drop_cnt  = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dht11_uart_reporter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dht11_uart_reporter
// Brief    : Directed self-checking bench for dht11_uart_reporter
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_dht11_uart_reporter;

    logic        clk = 1'b0;
    logic        rst, en, dht11_valid, tx_ready;
    logic        done_main, done_nerr, done_lf;
    logic [15:0] humidity, temperature;

    logic [7:0]  m_tx_data, n_tx_data, l_tx_data;
    logic        m_tx_valid, n_tx_valid, l_tx_valid;
    logic        m_busy, n_busy, l_busy;
    logic [15:0] m_frame, n_frame, l_frame;
    logic [7:0]  m_err, n_err, l_err, m_drop, n_drop, l_drop;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int ready_mode = 0;
    logic [7:0] q_main[$];
    int         q_cyc[$];
    logic [7:0] q_lf[$];
    int         bp_viol    = 0;
    int         nerr_valid = 0;
    logic       pend = 1'b0;
    logic [7:0] pend_data = 8'h00;

    always #5 clk = ~clk;

    dht11_uart_reporter #(.SEND_ERR(1'b1), .EOL_CRLF(1'b1)) dut (
        .clk(clk), .rst(rst), .en(en), .humidity(humidity), .temperature(temperature),
        .dht11_done(done_main), .dht11_valid(dht11_valid), .tx_data(m_tx_data),
        .tx_valid(m_tx_valid), .tx_ready(tx_ready), .busy(m_busy),
        .frame_cnt(m_frame), .err_cnt(m_err), .drop_cnt(m_drop));

    dht11_uart_reporter #(.SEND_ERR(1'b0), .EOL_CRLF(1'b1)) dut_nerr (
        .clk(clk), .rst(rst), .en(en), .humidity(humidity), .temperature(temperature),
        .dht11_done(done_nerr), .dht11_valid(dht11_valid), .tx_data(n_tx_data),
        .tx_valid(n_tx_valid), .tx_ready(1'b1), .busy(n_busy),
        .frame_cnt(n_frame), .err_cnt(n_err), .drop_cnt(n_drop));

    dht11_uart_reporter #(.SEND_ERR(1'b1), .EOL_CRLF(1'b0)) dut_lf (
        .clk(clk), .rst(rst), .en(en), .humidity(humidity), .temperature(temperature),
        .dht11_done(done_lf), .dht11_valid(dht11_valid), .tx_data(l_tx_data),
        .tx_valid(l_tx_valid), .tx_ready(1'b1), .busy(l_busy),
        .frame_cnt(l_frame), .err_cnt(l_err), .drop_cnt(l_drop));

    // Byte capture and hold-while-stalled monitoring, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst === 1'b1 && pend && !(m_tx_valid === 1'b1 && m_tx_data === pend_data))
            bp_viol++;
        pend      = (m_tx_valid === 1'b1) && (tx_ready === 1'b0);
        pend_data = m_tx_data;
        if (m_tx_valid === 1'b1 && tx_ready === 1'b1) begin
            q_main.push_back(m_tx_data);
            q_cyc.push_back(cyc);
        end
        if (l_tx_valid === 1'b1) q_lf.push_back(l_tx_data);
        if (n_tx_valid === 1'b1) nerr_valid++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        case (ready_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = ($urandom_range(0, 9) < 3);
            default: tx_ready = 1'b0;
        endcase
    endtask

    task automatic wait_bytes(input int target, input int budget, input bit lf_q);
        for (int i = 0; i < budget; i++) begin
            if ((lf_q ? q_lf.size() : q_main.size()) >= target) break;
            tick();
        end
    endtask

    task automatic check_line(input string tag, input string body, input bit crlf,
                              input bit lf_q, input int base);
        logic [7:0] e[$];
        logic [7:0] got;
        int n;
        for (int i = 0; i < body.len(); i++) e.push_back(body[i]);
        if (crlf) e.push_back(8'h0D);
        e.push_back(8'h0A);
        n = lf_q ? q_lf.size() : q_main.size();
        check({tag, "_len"}, n - base, e.size());
        for (int i = 0; i < e.size(); i++) begin
            if (base + i < n) got = lf_q ? q_lf[base + i] : q_main[base + i];
            else              got = 8'h00;
            check($sformatf("%s_b%0d", tag, i), got, e[i]);
        end
    endtask

    task automatic pulse_main();
        done_main = 1'b1;
        repeat (3) tick();
        done_main = 1'b0;
    endtask

    initial begin
        int base, lb, t0, lat, nv0;
        rst = 1'b0; en = 1'b1; dht11_valid = 1'b0; tx_ready = 1'b1;
        done_main = 1'b0; done_nerr = 1'b0; done_lf = 1'b0;
        humidity = 16'h0000; temperature = 16'h0000;
        repeat (5) tick();
        check("rst_tx_valid", m_tx_valid, 0);
        check("rst_tx_data", m_tx_data, 8'h00);
        check("rst_busy", m_busy, 0);
        check("rst_counters", {m_frame, m_err, m_drop}, 0);
        rst = 1'b1;
        repeat (3) tick();

        // Valid line, no backpressure, done held high for a long time
        humidity = 16'h2D00; temperature = 16'h1701; dht11_valid = 1'b1;
        base = q_main.size();
        done_main = 1'b1; t0 = cyc; lat = -1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (m_tx_valid === 1'b1) begin lat = cyc - t0 - 1; break; end
        end
        check("first_valid_le24", (lat >= 0 && lat <= 24), 1);
        wait_bytes(base + 17, 100, 0);
        repeat (5) tick();
        check_line("valid", "H:045.0 T:023.1", 1, 0, base);
        check("consecutive", (q_main.size() >= base + 17) ? q_cyc[base + 16] - q_cyc[base] : -1, 16);
        check("frame_1", m_frame, 1);
        repeat (5100) tick();
        check("long_done_bytes", q_main.size() - base, 17);
        check("long_done_frame", m_frame, 1);
        done_main = 1'b0;
        repeat (3) tick();

        // Backpressure
        ready_mode = 1;
        base = q_main.size();
        pulse_main();
        wait_bytes(base + 17, 600, 0);
        ready_mode = 0;
        repeat (5) tick();
        check_line("bp", "H:045.0 T:023.1", 1, 0, base);
        check("bp_hold", bp_viol, 0);
        check("frame_2", m_frame, 2);

        // Invalid measurement
        dht11_valid = 1'b0;
        base = q_main.size();
        pulse_main();
        wait_bytes(base + 5, 100, 0);
        repeat (5) tick();
        check_line("err", "ERR", 1, 0, base);
        check("err_cnt_1", m_err, 1);
        check("frame_3", m_frame, 3);
        nv0 = nerr_valid;
        done_nerr = 1'b1;
        repeat (3) tick();
        done_nerr = 1'b0;
        repeat (40) tick();
        check("nerr_no_tx", nerr_valid - nv0, 0);
        check("nerr_err_cnt", n_err, 1);
        check("nerr_frame", n_frame, 0);
        check("nerr_busy", n_busy, 0);
        check("nerr_tx_data", n_tx_data, 8'h00);

        // Drop while busy: data change must not alter the line
        dht11_valid = 1'b1; humidity = 16'h2D00; temperature = 16'h1701;
        base = q_main.size();
        pulse_main();
        repeat (3) tick();
        humidity = 16'h1100; temperature = 16'h0505;
        pulse_main();
        wait_bytes(base + 17, 100, 0);
        repeat (5) tick();
        check_line("drop", "H:045.0 T:023.1", 1, 0, base);
        check("drop_cnt_1", m_drop, 1);
        check("frame_4", m_frame, 4);
        check("err_cnt_still_1", m_err, 1);

        // Drop with en=0
        en = 1'b0;
        base = q_main.size();
        pulse_main();
        repeat (40) tick();
        check("en0_no_bytes", q_main.size() - base, 0);
        check("drop_cnt_2", m_drop, 2);
        check("en0_frame", m_frame, 4);
        check("en0_busy", m_busy, 0);
        en = 1'b1;

        // Boundary values, CRLF and LF-only instances together
        humidity = 16'hFF0C; temperature = 16'h0000; dht11_valid = 1'b1;
        base = q_main.size(); lb = q_lf.size();
        done_main = 1'b1; done_lf = 1'b1;
        repeat (3) tick();
        done_main = 1'b0; done_lf = 1'b0;
        wait_bytes(base + 17, 100, 0);
        repeat (5) tick();
        check_line("bound", "H:255.9 T:000.0", 1, 0, base);
        check_line("bound_lf", "H:255.9 T:000.0", 0, 1, lb);
        check("lf_frame", l_frame, 1);
        check("lf_err_drop", {l_err, l_drop, 7'd0, l_busy}, 0);
        check("nerr_drop", n_drop, 0);

        // Reset mid-line
        humidity = 16'h2D00; temperature = 16'h1701;
        base = q_main.size();
        done_main = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (q_main.size() >= base + 6) break;
            tick();
        end
        check("pre_reset_bytes", q_main.size() - base, 6);
        rst = 1'b0; tx_ready = 1'b0; ready_mode = 2;
        tick();
        check("midrst_tx_valid", m_tx_valid, 0);
        check("midrst_tx_data", m_tx_data, 8'h00);
        check("midrst_busy", m_busy, 0);
        check("midrst_counters", {m_frame, m_err, m_drop}, 0);
        repeat (2) tick();
        rst = 1'b1; ready_mode = 0;
        base = q_main.size();
        repeat (40) tick();
        check("held_done_no_capture", q_main.size() - base, 0);
        check("held_done_busy", m_busy, 0);
        done_main = 1'b0;
        repeat (3) tick();
        base = q_main.size();
        pulse_main();
        wait_bytes(base + 17, 100, 0);
        repeat (5) tick();
        check_line("post_rst", "H:045.0 T:023.1", 1, 0, base);
        check("post_rst_frame", m_frame, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
